// File: rtl/red_pitaya_daisy_pkg.sv
// Shared daisy-chain link definitions: FSM encoding and training word.
package red_pitaya_daisy_pkg;

  localparam int unsigned DAISY_W     = 16;
  localparam int unsigned DAISY_OFF_W = 4;

  // Word the far-end transmitter sends while training is requested
  localparam logic [DAISY_W-1:0] DAISY_TRAIN_WORD = 16'h00FF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_CONFIRM,
    ST_LOCKED
  } daisy_state_e;

endpackage

// File: rtl/red_pitaya_daisy_bitslip.sv
// Bit-slip stage: keeps the previous raw word and selects a 16-bit window
// out of {current, previous} at the given offset. The window is available
// combinationally for the aligner FSM and is captured into o_dat on i_load.
module red_pitaya_daisy_bitslip
  import red_pitaya_daisy_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dv,
  input  logic [DAISY_W-1:0]     i_dat,
  input  logic [DAISY_OFF_W-1:0] i_off,
  input  logic                   i_load,
  output logic [DAISY_W-1:0]     o_aligned_c,
  output logic [DAISY_W-1:0]     o_dat
);

  logic [DAISY_W-1:0]   r_prev;
  logic [2*DAISY_W-1:0] w_cat;

  // Offset d picks bits [d+15:d] of the concatenated pair
  assign w_cat       = {i_dat, r_prev};
  assign o_aligned_c = 16'(w_cat >> i_off);

  // Previous-word history and held output word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= '0;
      o_dat  <= '0;
    end else begin
      if (i_dv) begin
        r_prev <= i_dat;
      end
      if (i_load) begin
        o_dat <= o_aligned_c;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_daisy_align.sv
// Daisy-chain RX word aligner and training responder.
// Sweeps the bit-slip offset until TRAIN_WORD is seen LOCK_CNT times in a
// row, then freezes the offset and forwards aligned non-zero payload words.
// Optional mismatch counter while locked in training: DAISY_ALIGN_ERRCNT_EN.
module red_pitaya_daisy_align
  import red_pitaya_daisy_pkg::*;
#(
  parameter logic [15:0] TRAIN_WORD = DAISY_TRAIN_WORD,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned SLIP_WAIT  = 2
) (
  input  logic        par_clk_i,
  input  logic        par_rst_i,
  input  logic        cfg_en_i,
  input  logic        cfg_train_i,
  input  logic        raw_dv_i,
  input  logic [15:0] raw_dat_i,
  output logic        par_dv_o,
  output logic [15:0] par_dat_o,
  output logic        cfg_trained_o,
  output logic        cfg_fail_o,
  output logic [3:0]  cfg_off_o,
  output logic [15:0] err_cnt_o
);

  daisy_state_e     r_state, w_state_nxt;
  logic [3:0]       r_off, w_off_nxt;
  logic [3:0]       r_wait, w_wait_nxt;
  logic [3:0]       r_sweep, w_sweep_nxt;
  logic [7:0]       r_match, w_match_nxt;
  logic             r_fail, w_fail_nxt;
  logic             r_train_d;
  logic [15:0]      w_aligned;
  logic             w_hit;
  logic             w_fwd;

  red_pitaya_daisy_bitslip u_bitslip (
    .i_clk       (par_clk_i),
    .i_rst       (par_rst_i),
    .i_dv        (raw_dv_i),
    .i_dat       (raw_dat_i),
    .i_off       (r_off),
    .i_load      (w_fwd),
    .o_aligned_c (w_aligned),
    .o_dat       (par_dat_o)
  );

  assign w_hit = (w_aligned == TRAIN_WORD);
  assign w_fwd = cfg_en_i && raw_dv_i && (r_state == ST_LOCKED) &&
                 !cfg_train_i && (w_aligned != 16'h0);

  // Next-state and counter logic; disable overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    w_off_nxt   = r_off;
    w_wait_nxt  = r_wait;
    w_sweep_nxt = r_sweep;
    w_match_nxt = r_match;
    w_fail_nxt  = r_fail;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en_i && cfg_train_i) begin
          w_state_nxt = ST_SEARCH;
          w_off_nxt   = 4'd0;
          w_wait_nxt  = 4'd0;
          w_sweep_nxt = 4'd0;
          w_match_nxt = 8'd0;
          w_fail_nxt  = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (!cfg_train_i) begin
          w_state_nxt = ST_IDLE;
        end else if (raw_dv_i) begin
          if (r_wait != 4'd0) begin
            w_wait_nxt = r_wait - 4'd1;
          end else if (w_hit) begin
            // A candidate ends the current sweep
            w_match_nxt = 8'd1;
            w_sweep_nxt = 4'd0;
            w_state_nxt = (8'(LOCK_CNT) == 8'd1) ? ST_LOCKED : ST_CONFIRM;
          end else begin
            w_off_nxt  = r_off + 4'd1;
            w_wait_nxt = 4'(SLIP_WAIT);
            if (r_sweep == 4'd15) begin
              w_fail_nxt  = 1'b1;
              w_sweep_nxt = 4'd0;
            end else begin
              w_sweep_nxt = r_sweep + 4'd1;
            end
          end
        end
      end
      ST_CONFIRM: begin
        if (!cfg_train_i) begin
          w_state_nxt = ST_IDLE;
        end else if (raw_dv_i) begin
          if (w_hit) begin
            w_match_nxt = r_match + 8'd1;
            if ((r_match + 8'd1) == 8'(LOCK_CNT)) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_off_nxt   = r_off + 4'd1;
            w_wait_nxt  = 4'(SLIP_WAIT);
            w_match_nxt = 8'd0;
            w_state_nxt = ST_SEARCH;
          end
        end
      end
      ST_LOCKED: begin
        // Retrain from the frozen offset on a fresh training request
        if (cfg_train_i && !r_train_d) begin
          w_state_nxt = ST_SEARCH;
          w_wait_nxt  = 4'd0;
          w_sweep_nxt = 4'd0;
          w_match_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (!cfg_en_i) begin
      w_state_nxt = ST_IDLE;
      w_match_nxt = 8'd0;
      w_fail_nxt  = 1'b0;
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge par_clk_i) begin
    if (par_rst_i) begin
      r_state       <= ST_IDLE;
      r_off         <= 4'd0;
      r_wait        <= 4'd0;
      r_sweep       <= 4'd0;
      r_match       <= 8'd0;
      r_fail        <= 1'b0;
      r_train_d     <= 1'b0;
      cfg_trained_o <= 1'b0;
      par_dv_o      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_off         <= w_off_nxt;
      r_wait        <= w_wait_nxt;
      r_sweep       <= w_sweep_nxt;
      r_match       <= w_match_nxt;
      r_fail        <= w_fail_nxt;
      r_train_d     <= cfg_train_i;
      cfg_trained_o <= (w_state_nxt == ST_LOCKED);
      par_dv_o      <= w_fwd;
    end
  end

  assign cfg_fail_o = r_fail;
  assign cfg_off_o  = r_off;

`ifdef DAISY_ALIGN_ERRCNT_EN
  logic [15:0] r_err;

  // Saturating count of bad training words seen while locked
  always_ff @(posedge par_clk_i) begin
    if (par_rst_i) begin
      r_err <= 16'h0;
    end else if ((w_state_nxt == ST_SEARCH) && (r_state != ST_SEARCH)) begin
      r_err <= 16'h0;
    end else if ((r_state == ST_LOCKED) && cfg_en_i && cfg_train_i &&
                 raw_dv_i && !w_hit && (r_err != 16'hFFFF)) begin
      r_err <= r_err + 16'd1;
    end
  end

  assign err_cnt_o = r_err;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule

// File: doc/red_pitaya_daisy_align.md
Name: red_pitaya_daisy_align

Overview:
Receive-side word aligner and training responder for the daisy-chain link. It consumes unaligned 16-bit words from the deserializer and, while training is requested, bit-slips across 16 offsets until the transmitter's training word (16'h00FF) is seen LOCK_CNT times in a row. It then freezes the offset, reports trained, and forwards aligned payload words to the parallel RX port. It sits between the deserializer and the RX data/status path in the recovered parallel clock domain.

Parameters:
TRAIN_WORD, 16'h00FF, training pattern sent by the far-end transmitter in training mode
LOCK_CNT, 8, consecutive matching valid beats required to declare lock (range 1..255)
SLIP_WAIT, 2, valid beats ignored after each offset change before comparing again (range 0..15)

Ports:
par_clk_i  in  1  parallel RX clock; the only clock
par_rst_i  in  1  synchronous reset, active high
cfg_en_i  in  1  block enable; low forces IDLE
cfg_train_i  in  1  training request, level
raw_dv_i  in  1  raw word valid
raw_dat_i  in  16  raw word; bit 0 is earliest on the wire
par_dv_o  out  1  aligned word valid
par_dat_o  out  16  aligned word
cfg_trained_o  out  1  lock achieved, offset frozen
cfg_fail_o  out  1  sticky: full 16-offset sweep found no candidate
cfg_off_o  out  4  current slip offset
err_cnt_o  out  16  training mismatch count (optional feature)

Behaviour:
- Reset (par_rst_i=1 on a clock edge): state IDLE, offset 0, all outputs 0, prev word 0, counters 0.
- Alignment: on raw_dv_i, cat = {raw_dat_i, prev}, aligned = cat[off+15:off], prev <= raw_dat_i. Stream delay d bits maps to off=d.
- par_dv_o/par_dat_o registered: 1-cycle latency from raw_dv_i. Valid only in LOCKED with cfg_train_i=0 and aligned != 16'h0; otherwise par_dv_o=0 and par_dat_o holds its last value.
- FSM states, evaluated per cycle:
  IDLE: cfg_en_i & cfg_train_i -> SEARCH, off=0, wait=0, fail=0, sweep=0.
  SEARCH: on valid beat with wait>0, wait--. Otherwise, if aligned==TRAIN_WORD -> CONFIRM, match=1. If not, off++ (15 wraps to 0), wait=SLIP_WAIT, sweep++. When sweep reaches 16, set cfg_fail_o, clear sweep, and keep searching.
  CONFIRM: on valid beat, match -> match++; reaching LOCK_CNT -> LOCKED. Mismatch -> off++, wait=SLIP_WAIT, -> SEARCH.
  LOCKED: cfg_trained_o=1, off frozen. Rising edge of cfg_train_i -> SEARCH (retrain, trained cleared, off retained as start point).
- cfg_en_i=0 in any state -> IDLE next cycle. Trained, dv, fail and match clear; off holds.
- raw_dv_i=0: no compare, no counter change, no prev update.
- LOCK_CNT=1: the first match goes straight to LOCKED and skips CONFIRM.
- Simultaneous cfg_en_i fall and a lock event: disable wins.
- cfg_train_i falling in SEARCH/CONFIRM -> IDLE. cfg_fail_o is sticky until the next IDLE->SEARCH.

Optional Feature:
DAISY_ALIGN_ERRCNT_EN defined: in LOCKED with cfg_train_i=1, each valid beat whose aligned word != TRAIN_WORD increments err_cnt_o. The counter saturates at 16'hFFFF and clears on entry to SEARCH or on reset. Undefined: err_cnt_o is tied to 16'h0 and the counter is not synthesized.

Decomposition:
- Shared package red_pitaya_daisy_pkg: FSM state encoding (IDLE, SEARCH, CONFIRM, LOCKED) and DAISY_TRAIN_WORD = 16'h00FF, shared with the TX data selector.
- One sub-module, red_pitaya_daisy_bitslip: prev register plus the 32->16 offset mux, 1-cycle registered output.
- FSM and counters stay in the top module.

Test Plan:
- Continuous 00FF stream delayed d=5 bits, cfg_en_i=1, cfg_train_i=1 -> cfg_off_o=5, cfg_trained_o=1 within 16*(SLIP_WAIT+1)+LOCK_CNT valid beats; cfg_fail_o=0.
- After lock, drop cfg_train_i and send 16'h1234, 16'h0000, 16'hABCD -> par_dat_o 1234 and ABCD, each 1 cycle after input; no dv for the zero word.
- d=0 stream with one corrupted word during CONFIRM at match=3 -> return to SEARCH and off=1; off wraps 15->0; final lock at off=0.
- All-zero stream, 17*(SLIP_WAIT+1) valid beats -> cfg_fail_o=1 and stays 1; re-raising training from IDLE clears it.
- par_rst_i or cfg_en_i=0 asserted while LOCKED -> next cycle cfg_trained_o=0 and par_dv_o=0; on reset, cfg_off_o=0.
- With DAISY_ALIGN_ERRCNT_EN defined: locked, training held, 3 corrupt words -> err_cnt_o=3. Undefined: err_cnt_o=0.
